// File: rtl/ibex_register_file_fpga_mp.sv
// Multi-write-port FPGA register file using a Live-Value-Table: one RAM bank per write port,
// replicated per read port, with a post-reset sweep that restores every register to WordZeroVal.
module ibex_register_file_fpga_mp #(
    parameter bit                    RV32E         = 1'b0,
    parameter int unsigned           DataWidth     = 32,
    parameter int unsigned           NumReadPorts  = 3,
    parameter int unsigned           NumWritePorts = 2,
    parameter bit                    WriteBypass   = 1'b0,
    parameter logic [DataWidth-1:0]  WordZeroVal   = '0
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                test_en_i,
    input  logic                                dummy_instr_id_i,
    input  logic [5*NumReadPorts-1:0]           raddr_i,
    output logic [DataWidth*NumReadPorts-1:0]   rdata_o,
    input  logic [5*NumWritePorts-1:0]          waddr_i,
    input  logic [DataWidth*NumWritePorts-1:0]  wdata_i,
    input  logic [NumWritePorts-1:0]            we_i,
    output logic                                init_busy_o,
    output logic                                wr_conflict_o
);

    localparam int unsigned AW      = RV32E ? 4 : 5;
    localparam int unsigned NumRegs = 2 ** AW;
    localparam int unsigned LW      = (NumWritePorts > 1) ? $clog2(NumWritePorts) : 1;

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StRun   = 1'b1;

    logic [0:0]           state_q;
    logic [AW-1:0]        clr_cnt_q;
    logic                 run;

    logic [AW-1:0]        waddr   [NumWritePorts];
    logic [DataWidth-1:0] wdata   [NumWritePorts];
    logic [NumWritePorts-1:0] bank_we;
    logic [AW-1:0]        raddr   [NumReadPorts];
    logic [LW-1:0]        rsel    [NumReadPorts];
    logic [DataWidth-1:0] rd;

    logic [DataWidth-1:0] bank_q [NumWritePorts][NumReadPorts][NumRegs];

    logic unused_sink;
    assign unused_sink = ^{test_en_i, dummy_instr_id_i, raddr_i, waddr_i};

    assign run         = (state_q == StRun);
    assign init_busy_o = (state_q == StClear);

    // Only the low AW address bits matter; x0 writes never reach a bank.
    always_comb begin
        bank_we = '0;
        for (int w = 0; w < NumWritePorts; w++) begin
            waddr[w]   = waddr_i[5*w +: AW];
            wdata[w]   = wdata_i[DataWidth*w +: DataWidth];
            bank_we[w] = run & we_i[w] & (waddr_i[5*w +: AW] != '0);
        end
        for (int p = 0; p < NumReadPorts; p++) begin
            raddr[p] = raddr_i[5*p +: AW];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StClear;
            clr_cnt_q <= AW'(1);
        end else if (state_q == StClear) begin
            clr_cnt_q <= clr_cnt_q + AW'(1);
            if (clr_cnt_q == AW'(NumRegs - 1)) begin
                state_q <= StRun;
            end
        end
    end

    // Distributed RAM has no reset; the sweep rewrites bank 0 while the LVT points everyone there.
    always @(posedge clk_i) begin
        for (int w = 0; w < NumWritePorts; w++) begin
            for (int p = 0; p < NumReadPorts; p++) begin
                if (bank_we[w]) begin
                    bank_q[w][p][waddr[w]] <= wdata[w];
                end
            end
        end
        if (!run) begin
            for (int p = 0; p < NumReadPorts; p++) begin
                bank_q[0][p][clr_cnt_q] <= WordZeroVal;
            end
        end
    end

    generate
        if (NumWritePorts > 1) begin : g_lvt
            logic [LW-1:0] lvt_q [NumRegs];
            logic          wr_conflict_q;

            // Higher-numbered ports are applied last, so port 1 wins a same-address collision.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int i = 0; i < NumRegs; i++) begin
                        lvt_q[i] <= '0;
                    end
                end else if (!run) begin
                    lvt_q[clr_cnt_q] <= '0;
                end else begin
                    for (int w = 0; w < NumWritePorts; w++) begin
                        if (bank_we[w]) begin
                            lvt_q[waddr[w]] <= LW'(w);
                        end
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    wr_conflict_q <= 1'b0;
                end else begin
                    wr_conflict_q <= bank_we[0] & bank_we[1] & (waddr[0] == waddr[1]);
                end
            end

            always_comb begin
                for (int p = 0; p < NumReadPorts; p++) begin
                    rsel[p] = lvt_q[raddr[p]];
                end
            end

            assign wr_conflict_o = wr_conflict_q;
        end else begin : g_no_lvt
            always_comb begin
                for (int p = 0; p < NumReadPorts; p++) begin
                    rsel[p] = '0;
                end
            end

            assign wr_conflict_o = 1'b0;
        end
    endgenerate

    // Read priority: x0, then the clear override, then bypass, then the LVT-selected bank.
    always_comb begin
        rdata_o = '0;
        rd      = '0;
        for (int p = 0; p < NumReadPorts; p++) begin
            rd = bank_q[rsel[p]][p][raddr[p]];
            if (WriteBypass) begin
                for (int w = 0; w < NumWritePorts; w++) begin
                    if (bank_we[w] && (waddr[w] == raddr[p])) begin
                        rd = wdata[w];
                    end
                end
            end
            if (!run) begin
                rd = WordZeroVal;
            end
            if (raddr[p] == '0) begin
                rd = '0;
            end
            rdata_o[DataWidth*p +: DataWidth] = rd;
        end
    end

endmodule

// File: tb/tb_ibex_register_file_fpga_mp.sv
// Bench for ibex_register_file_fpga_mp: default, write-bypass and RV32E instances checked
// against an array-based register model with directed scenarios plus a randomized run.
module tb_ibex_register_file_fpga_mp;

    localparam logic [31:0] WZV = 32'hDEADBEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_e_n;
    logic [14:0] raddr;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  we;

    logic [95:0] rd_m, rd_b, rd_e;
    logic        busy_m_o, busy_b_o, busy_e_o;
    logic        conf_m_o, conf_b_o, conf_e_o;

    ibex_register_file_fpga_mp #(.RV32E(1'b0), .WriteBypass(1'b0), .WordZeroVal(WZV)) dut_m (
        .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0), .dummy_instr_id_i(1'b0),
        .raddr_i(raddr), .rdata_o(rd_m), .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .init_busy_o(busy_m_o), .wr_conflict_o(conf_m_o));

    ibex_register_file_fpga_mp #(.RV32E(1'b0), .WriteBypass(1'b1), .WordZeroVal(WZV)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0), .dummy_instr_id_i(1'b0),
        .raddr_i(raddr), .rdata_o(rd_b), .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .init_busy_o(busy_b_o), .wr_conflict_o(conf_b_o));

    ibex_register_file_fpga_mp #(.RV32E(1'b1), .WriteBypass(1'b0), .WordZeroVal(WZV)) dut_e (
        .clk_i(clk), .rst_ni(rst_e_n), .test_en_i(1'b0), .dummy_instr_id_i(1'b0),
        .raddr_i(raddr), .rdata_o(rd_e), .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .init_busy_o(busy_e_o), .wr_conflict_o(conf_e_o));

    // Reference: architectural register contents plus remaining clear cycles per instance.
    logic [31:0] mem_m [32];
    logic [31:0] mem_e [16];
    int          busy_m, busy_e;
    bit          conf_m, conf_e;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] exp_m(int p, bit byp);
        logic [4:0] a;
        a = raddr[5*p +: 5];
        if (a == 5'd0) return 32'h0;
        if (busy_m > 0) return WZV;
        if (byp) begin
            if (we[1] && waddr[9:5] == a) return wdata[63:32];
            if (we[0] && waddr[4:0] == a) return wdata[31:0];
        end
        return mem_m[a];
    endfunction

    function automatic logic [31:0] exp_e(int p);
        logic [3:0] a;
        a = raddr[5*p +: 4];
        if (a == 4'd0) return 32'h0;
        if (busy_e > 0) return WZV;
        return mem_e[a];
    endfunction

    task automatic tick();
        logic [4:0] a0, a1;
        logic [3:0] e0, e1;
        a0 = waddr[4:0];
        a1 = waddr[9:5];
        e0 = waddr[3:0];
        e1 = waddr[8:5];
        if (!rst_n) begin
            busy_m = 31;
            conf_m = 1'b0;
            for (int i = 0; i < 32; i++) mem_m[i] = WZV;
        end else if (busy_m > 0) begin
            busy_m--;
            conf_m = 1'b0;
        end else begin
            conf_m = (we == 2'b11) && (a0 == a1) && (a0 != 5'd0);
            if (we[0] && a0 != 5'd0) mem_m[a0] = wdata[31:0];
            if (we[1] && a1 != 5'd0) mem_m[a1] = wdata[63:32];
        end
        if (!rst_e_n) begin
            busy_e = 15;
            conf_e = 1'b0;
            for (int i = 0; i < 16; i++) mem_e[i] = WZV;
        end else if (busy_e > 0) begin
            busy_e--;
            conf_e = 1'b0;
        end else begin
            conf_e = (we == 2'b11) && (e0 == e1) && (e0 != 4'd0);
            if (we[0] && e0 != 4'd0) mem_e[e0] = wdata[31:0];
            if (we[1] && e1 != 4'd0) mem_e[e1] = wdata[63:32];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cnt, cnt_e;
        we = 2'b00; raddr = '0; waddr = '0; wdata = '0;
        rst_n = 1'b0; rst_e_n = 1'b0;
        tick(); tick();
        n_cmp++; if (busy_m_o !== 1'b1) begin n_bad++; $display("FAIL reset_busy got=%b want=1", busy_m_o); end
        n_cmp++; if (conf_m_o !== 1'b0) begin n_bad++; $display("FAIL reset_conflict got=%b want=0", conf_m_o); end
        rst_n = 1'b1; rst_e_n = 1'b1;
        raddr = {5'd0, 5'd0, 5'd5};
        waddr = {5'd0, 5'd5};
        wdata = {32'h0, 32'h12345678};
        we    = 2'b01;
        cnt = 0; cnt_e = -1;
        while (busy_m_o && cnt < 100) begin
            #1;
            n_cmp++; if (rd_m[31:0] !== WZV) begin n_bad++; $display("FAIL busy_read cyc=%0d got=%h want=%h", cnt, rd_m[31:0], WZV); end
            if (!busy_e_o && cnt_e < 0) cnt_e = cnt;
            tick();
            cnt++;
        end
        we = 2'b00;
        #1;
        n_cmp++; if (cnt !== 31) begin n_bad++; $display("FAIL sweep_len got=%0d want=31", cnt); end
        n_cmp++; if (cnt_e !== 15) begin n_bad++; $display("FAIL sweep_len_e got=%0d want=15", cnt_e); end
        n_cmp++; if (rd_m[31:0] !== WZV) begin n_bad++; $display("FAIL busy_write_ignored got=%h want=%h", rd_m[31:0], WZV); end
    endtask

    task automatic test_dual_write();
        waddr = {5'd7, 5'd3};
        wdata = {32'h22, 32'h11};
        we    = 2'b11;
        tick();
        we    = 2'b00;
        raddr = {5'd0, 5'd7, 5'd3};
        #1;
        n_cmp++; if (rd_m[31:0]  !== 32'h11) begin n_bad++; $display("FAIL dual_rd0 got=%h want=%h", rd_m[31:0], 32'h11); end
        n_cmp++; if (rd_m[63:32] !== 32'h22) begin n_bad++; $display("FAIL dual_rd1 got=%h want=%h", rd_m[63:32], 32'h22); end
        n_cmp++; if (rd_m[95:64] !== 32'h0)  begin n_bad++; $display("FAIL dual_rd2 got=%h want=0", rd_m[95:64]); end
        n_cmp++; if (conf_m_o !== 1'b0) begin n_bad++; $display("FAIL dual_conflict got=%b want=0", conf_m_o); end
    endtask

    task automatic test_conflict();
        waddr = {5'd9, 5'd9};
        wdata = {32'hBB, 32'hAA};
        we    = 2'b11;
        tick();
        we    = 2'b00;
        raddr = {5'd0, 5'd0, 5'd9};
        #1;
        n_cmp++; if (rd_m[31:0] !== 32'hBB) begin n_bad++; $display("FAIL conflict_winner got=%h want=%h", rd_m[31:0], 32'hBB); end
        n_cmp++; if (conf_m_o !== 1'b1) begin n_bad++; $display("FAIL conflict_pulse got=%b want=1", conf_m_o); end
        tick();
        n_cmp++; if (conf_m_o !== 1'b0) begin n_bad++; $display("FAIL conflict_one_cycle got=%b want=0", conf_m_o); end
        waddr = {5'd0, 5'd9};
        wdata = {32'h0, 32'hCC};
        we    = 2'b01;
        tick();
        we = 2'b00;
        #1;
        n_cmp++; if (rd_m[31:0] !== 32'hCC) begin n_bad++; $display("FAIL lvt_back_to_0 got=%h want=%h", rd_m[31:0], 32'hCC); end
        n_cmp++; if (conf_m_o !== 1'b0) begin n_bad++; $display("FAIL single_write_conflict got=%b want=0", conf_m_o); end
    endtask

    task automatic test_x0();
        waddr = {5'd0, 5'd0};
        wdata = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        we    = 2'b11;
        tick();
        we    = 2'b00;
        raddr = '0;
        #1;
        n_cmp++; if (rd_m !== 96'h0) begin n_bad++; $display("FAIL x0_read got=%h want=0", rd_m); end
        n_cmp++; if (conf_m_o !== 1'b0) begin n_bad++; $display("FAIL x0_conflict got=%b want=0", conf_m_o); end
    endtask

    task automatic test_bypass();
        waddr = {5'd0, 5'd4};
        wdata = {32'h0, 32'h44};
        we    = 2'b01;
        tick();
        wdata = {32'h0, 32'h55};
        raddr = {5'd0, 5'd0, 5'd4};
        #1;
        n_cmp++; if (rd_b[31:0] !== 32'h55) begin n_bad++; $display("FAIL bypass_new got=%h want=%h", rd_b[31:0], 32'h55); end
        n_cmp++; if (rd_m[31:0] !== 32'h44) begin n_bad++; $display("FAIL nobypass_old got=%h want=%h", rd_m[31:0], 32'h44); end
        tick();
        we = 2'b00;
        #1;
        n_cmp++; if (rd_m[31:0] !== 32'h55) begin n_bad++; $display("FAIL nobypass_next got=%h want=%h", rd_m[31:0], 32'h55); end
    endtask

    task automatic test_rv32e();
        int cnt;
        waddr = {5'd0, 5'h13};
        wdata = {32'h0, 32'h77};
        we    = 2'b01;
        tick();
        we    = 2'b00;
        raddr = {5'd0, 5'h13, 5'h03};
        #1;
        n_cmp++; if (rd_e[31:0]  !== 32'h77) begin n_bad++; $display("FAIL e_x3 got=%h want=%h", rd_e[31:0], 32'h77); end
        n_cmp++; if (rd_e[63:32] !== 32'h77) begin n_bad++; $display("FAIL e_bit4_ignored got=%h want=%h", rd_e[63:32], 32'h77); end
        n_cmp++; if (rd_m[63:32] !== 32'h77) begin n_bad++; $display("FAIL main_x19 got=%h want=%h", rd_m[63:32], 32'h77); end
        n_cmp++; if (rd_m[31:0]  !== 32'h11) begin n_bad++; $display("FAIL main_x3 got=%h want=%h", rd_m[31:0], 32'h11); end
        rst_e_n = 1'b0;
        tick();
        rst_e_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (busy_e_o !== 1'b1) begin n_bad++; $display("FAIL e_busy_partial cyc=%0d got=%b want=1", i, busy_e_o); end
            tick();
        end
        rst_e_n = 1'b0;
        tick();
        rst_e_n = 1'b1;
        cnt = 0;
        while (busy_e_o && cnt < 100) begin
            tick();
            cnt++;
        end
        #1;
        n_cmp++; if (cnt !== 15) begin n_bad++; $display("FAIL e_restart_len got=%0d want=15", cnt); end
        n_cmp++; if (rd_e[31:0] !== WZV) begin n_bad++; $display("FAIL e_cleared got=%h want=%h", rd_e[31:0], WZV); end
    endtask

    task automatic test_random();
        logic [4:0] a0, a1, r;
        for (int it = 0; it < 400; it++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            rst_e_n = ($urandom_range(0, 149) != 0);
            a0 = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) a0 = 5'd0;
            waddr = {a1, a0};
            wdata = {$urandom, $urandom};
            we    = 2'($urandom);
            for (int p = 0; p < 3; p++) begin
                case ($urandom_range(0, 2))
                    0: r = a0;
                    1: r = a1;
                    default: r = 5'($urandom_range(0, 31));
                endcase
                raddr[5*p +: 5] = r;
            end
            #1;
            for (int p = 0; p < 3; p++) begin
                n_cmp++; if (rd_m[32*p +: 32] !== exp_m(p, 1'b0)) begin n_bad++; $display("FAIL rnd_main it=%0d port=%0d got=%h want=%h", it, p, rd_m[32*p +: 32], exp_m(p, 1'b0)); end
                n_cmp++; if (rd_b[32*p +: 32] !== exp_m(p, 1'b1)) begin n_bad++; $display("FAIL rnd_byp it=%0d port=%0d got=%h want=%h", it, p, rd_b[32*p +: 32], exp_m(p, 1'b1)); end
                n_cmp++; if (rd_e[32*p +: 32] !== exp_e(p)) begin n_bad++; $display("FAIL rnd_e it=%0d port=%0d got=%h want=%h", it, p, rd_e[32*p +: 32], exp_e(p)); end
            end
            tick();
            n_cmp++; if (conf_m_o !== conf_m) begin n_bad++; $display("FAIL rnd_conf it=%0d got=%b want=%b", it, conf_m_o, conf_m); end
            n_cmp++; if (conf_b_o !== conf_m) begin n_bad++; $display("FAIL rnd_conf_byp it=%0d got=%b want=%b", it, conf_b_o, conf_m); end
            n_cmp++; if (conf_e_o !== conf_e) begin n_bad++; $display("FAIL rnd_conf_e it=%0d got=%b want=%b", it, conf_e_o, conf_e); end
            n_cmp++; if (busy_m_o !== (busy_m > 0)) begin n_bad++; $display("FAIL rnd_busy it=%0d got=%b want=%b", it, busy_m_o, busy_m > 0); end
            n_cmp++; if (busy_e_o !== (busy_e > 0)) begin n_bad++; $display("FAIL rnd_busy_e it=%0d got=%b want=%b", it, busy_e_o, busy_e > 0); end
        end
        rst_n = 1'b1;
        rst_e_n = 1'b1;
        we = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        busy_m = 0; busy_e = 0; conf_m = 1'b0; conf_e = 1'b0;
        for (int i = 0; i < 32; i++) mem_m[i] = WZV;
        for (int i = 0; i < 16; i++) mem_e[i] = WZV;
        rst_n = 1'b0; rst_e_n = 1'b0;
        we = 2'b00; raddr = '0; waddr = '0; wdata = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_dual_write();
        test_conflict();
        test_x0();
        test_bypass();
        test_rv32e();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
